// File: rtl/egg_timer_controller_pkg.sv
// Shared definitions for the egg timer: state encodings, BCD digit limits
// and a BCD-to-binary helper used for the minute wrap compare.
package egg_timer_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
        return 7'(tens) * 7'd10 + 7'(ones);
    endfunction

endpackage

// File: rtl/egg_timer_controller_bcd_digit.sv
// One registered BCD digit with increment/decrement and wrap at a programmable limit.
// carry/borrow flag the wrap so digits can be chained.
module egg_timer_controller_bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       clear,
    input  logic [3:0] limit,
    output logic [3:0] value,
    output logic       carry,
    output logic       borrow
);

    assign carry  = inc & (value == limit);
    assign borrow = dec & (value == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= 4'd0;
        end else if (clear) begin
            value <= 4'd0;
        end else if (inc) begin
            value <= carry ? 4'd0 : value + 4'd1;
        end else if (dec) begin
            value <= borrow ? limit : value - 4'd1;
        end
    end

endmodule

// File: rtl/egg_timer_controller.sv
// Egg timer countdown sequencer: MM:SS in four chained BCD digits plus the
// IDLE/RUN/PAUSE/ALARM state machine and the alarm duration counter.
//
//   state | meaning
//   IDLE  | time settable with btnMin/btnSec, waiting for start
//   RUN   | counting down one second per tick
//   PAUSE | countdown frozen, btnStart resumes
//   ALARM | buzzer on at 00:00 for ALARM_TICKS ticks or until btnStart
module egg_timer_controller #(
    parameter int MAX_MIN     = 99,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btnStart,
    input  logic       btnMin,
    input  logic       btnSec,
    input  logic       btnClear,
    output logic [3:0] minTens,
    output logic [3:0] minOnes,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic [1:0] state,
    output logic       running,
    output logic       alarm
);
    import egg_timer_controller_pkg::*;

    localparam logic [6:0] MAX_MIN_B     = 7'(MAX_MIN);
    localparam logic [7:0] ALARM_TICKS_C = 8'(ALARM_TICKS);

    state_t     st;
    logic [7:0] alarm_cnt;

    logic sec_inc, min_inc, min_wrap, tick_dec;
    logic so_carry, so_borrow, st_carry, st_borrow;
    logic mo_carry, mo_borrow, mt_carry, mt_borrow;
    logic time_zero, time_one;
    logic unused_flags;

    // Clear and start outrank the setting buttons and the tick.
    assign sec_inc  = (st == IDLE) & btnSec & ~btnStart & ~btnClear;
    assign min_inc  = (st == IDLE) & btnMin & ~btnStart & ~btnClear;
    assign min_wrap = min_inc & (bcd2bin(minTens, minOnes) == MAX_MIN_B);
    assign tick_dec = (st == RUN) & tick & ~btnStart & ~btnClear;

    assign time_zero = ({minTens, minOnes, secTens, secOnes} == 16'h0000);
    assign time_one  = ({minTens, minOnes, secTens, secOnes} == 16'h0001);

    // Seconds wrap 59->00 without carrying into minutes.
    assign unused_flags = st_carry ^ mt_carry ^ mt_borrow;

    egg_timer_controller_bcd_digit u_sec_ones (
        .clk(clk), .reset(reset), .inc(sec_inc), .dec(tick_dec), .clear(btnClear),
        .limit(DIGIT_MAX), .value(secOnes), .carry(so_carry), .borrow(so_borrow)
    );

    egg_timer_controller_bcd_digit u_sec_tens (
        .clk(clk), .reset(reset), .inc(so_carry), .dec(so_borrow), .clear(btnClear),
        .limit(SEC_TENS_MAX), .value(secTens), .carry(st_carry), .borrow(st_borrow)
    );

    egg_timer_controller_bcd_digit u_min_ones (
        .clk(clk), .reset(reset), .inc(min_inc & ~min_wrap), .dec(st_borrow),
        .clear(btnClear | min_wrap), .limit(DIGIT_MAX), .value(minOnes),
        .carry(mo_carry), .borrow(mo_borrow)
    );

    egg_timer_controller_bcd_digit u_min_tens (
        .clk(clk), .reset(reset), .inc(mo_carry), .dec(mo_borrow),
        .clear(btnClear | min_wrap), .limit(DIGIT_MAX), .value(minTens),
        .carry(mt_carry), .borrow(mt_borrow)
    );

    assign state = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            alarm_cnt <= 8'd0;
            running   <= 1'b0;
            alarm     <= 1'b0;
        end else if (btnClear) begin
            st        <= IDLE;
            alarm_cnt <= 8'd0;
            running   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (btnStart && !time_zero) begin
                        st      <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (btnStart) begin
                        st      <= PAUSE;
                        running <= 1'b0;
                    end else if (tick && time_one) begin
                        // Digits reach 00:00 on this same edge.
                        st        <= ALARM;
                        running   <= 1'b0;
                        alarm     <= 1'b1;
                        alarm_cnt <= 8'd0;
                    end
                end
                PAUSE: begin
                    if (btnStart) begin
                        st      <= RUN;
                        running <= 1'b1;
                    end
                end
                ALARM: begin
                    if (btnStart || (tick && (alarm_cnt + 8'd1 == ALARM_TICKS_C))) begin
                        st        <= IDLE;
                        alarm     <= 1'b0;
                        alarm_cnt <= 8'd0;
                    end else if (tick) begin
                        alarm_cnt <= alarm_cnt + 8'd1;
                    end
                end
                default: begin
                    st      <= IDLE;
                    running <= 1'b0;
                    alarm   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_egg_timer_controller.sv
// Directed bench for egg_timer_controller: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_egg_timer_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, btnStart, btnMin, btnSec, btnClear;
    logic [3:0] minTens, minOnes, secTens, secOnes;
    logic [1:0] state;
    logic       running, alarm;

    egg_timer_controller #(.MAX_MIN(99), .ALARM_TICKS(10)) dut (
        .clk(clk), .reset(reset), .tick(tick), .btnStart(btnStart), .btnMin(btnMin),
        .btnSec(btnSec), .btnClear(btnClear), .minTens(minTens), .minOnes(minOnes),
        .secTens(secTens), .secOnes(secOnes), .state(state), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // {start, min, sec, clear, tick}
    localparam logic [4:0] S = 5'b10000;
    localparam logic [4:0] M = 5'b01000;
    localparam logic [4:0] C = 5'b00100;
    localparam logic [4:0] X = 5'b00010;
    localparam logic [4:0] T = 5'b00001;

    typedef struct {
        string       name;
        logic [19:0] v;   // {mmss BCD, state, running, alarm}
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cyc(input logic [4:0] b);
        {btnStart, btnMin, btnSec, btnClear, tick} = b;
        @(posedge clk);
        #1;
        {btnStart, btnMin, btnSec, btnClear, tick} = 5'b0;
    endtask

    task automatic rep(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) cyc(b);
    endtask

    task automatic expect_out(input string name, input logic [15:0] mmss,
                              input logic [1:0] st, input logic run, input logic alm);
        exp_t e;
        e.name = name;
        e.v    = {mmss, st, run, alm};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [19:0] act;
            e   = q.pop_front();
            act = {minTens, minOnes, secTens, secOnes, state, running, alarm};
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL %s: got mmss=%h st=%0d run=%b alm=%b, want mmss=%h st=%0d run=%b alm=%b",
                         e.name, act[19:4], act[3:2], act[1], act[0],
                         e.v[19:4], e.v[3:2], e.v[1], e.v[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {btnStart, btnMin, btnSec, btnClear, tick} = 5'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        expect_out("reset", 16'h0000, 2'd0, 1'b0, 1'b0);

        // 1: set 02:03, start, three ticks
        rep(C, 3); rep(M, 2);
        expect_out("set_0203", 16'h0203, 2'd0, 1'b0, 1'b0);
        cyc(S);
        expect_out("start_0203", 16'h0203, 2'd1, 1'b1, 1'b0);
        cyc(T);
        expect_out("tick1_0202", 16'h0202, 2'd1, 1'b1, 1'b0);
        rep(T, 2);
        expect_out("tick3_0200", 16'h0200, 2'd1, 1'b1, 1'b0);
        cyc(X);
        expect_out("clear1", 16'h0000, 2'd0, 1'b0, 1'b0);

        // 2: 00:02 countdown into alarm and auto-return
        rep(C, 2); cyc(S); cyc(T);
        expect_out("run_0001", 16'h0001, 2'd1, 1'b1, 1'b0);
        cyc(T);
        expect_out("alarm_enter", 16'h0000, 2'd3, 1'b0, 1'b1);
        rep(T, 9);
        expect_out("alarm_9ticks", 16'h0000, 2'd3, 1'b0, 1'b1);
        cyc(T);
        expect_out("alarm_10ticks", 16'h0000, 2'd0, 1'b0, 1'b0);

        // 3: minute borrow, pause with coincident tick, resume
        cyc(M); cyc(S); cyc(T);
        expect_out("borrow_0059", 16'h0059, 2'd1, 1'b1, 1'b0);
        cyc(S | T);
        expect_out("pause_tick_drop", 16'h0059, 2'd2, 1'b0, 1'b0);
        rep(T, 3);
        expect_out("pause_hold", 16'h0059, 2'd2, 1'b0, 1'b0);
        cyc(S); cyc(T);
        expect_out("resume_0058", 16'h0058, 2'd1, 1'b1, 1'b0);
        cyc(X);

        // 4: wrap limits in IDLE
        rep(C, 59);
        expect_out("sec_59", 16'h0059, 2'd0, 1'b0, 1'b0);
        cyc(C);
        expect_out("sec_wrap", 16'h0000, 2'd0, 1'b0, 1'b0);
        rep(M, 99);
        expect_out("min_99", 16'h9900, 2'd0, 1'b0, 1'b0);
        cyc(M);
        expect_out("min_wrap", 16'h0000, 2'd0, 1'b0, 1'b0);
        cyc(S);
        expect_out("start_at_zero", 16'h0000, 2'd0, 1'b0, 1'b0);
        cyc(M | C);
        expect_out("min_sec_both", 16'h0101, 2'd0, 1'b0, 1'b0);
        cyc(X);

        // 5: clear beats start and tick in RUN
        rep(M, 5); rep(C, 30); cyc(S);
        expect_out("run_0530", 16'h0530, 2'd1, 1'b1, 1'b0);
        cyc(X | S | T);
        expect_out("clear_priority", 16'h0000, 2'd0, 1'b0, 1'b0);

        // 6: asynchronous reset between edges mid-RUN
        cyc(M); cyc(S); cyc(T);
        expect_out("pre_reset_0059", 16'h0059, 2'd1, 1'b1, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        expect_out("async_reset", 16'h0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(T);
        expect_out("post_reset_tick", 16'h0000, 2'd0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
